// File: rtl/text_console.sv
// text_console: character-cell console buffer with cursor, scrolling via a circular row
// base, swept clears, and a registered screen-relative read port.
module text_console #(
    parameter int COLS  = 32,
    parameter int ROWS  = 16,
    parameter int COL_W = 5,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr,
    input  logic [7:0]       i_data,
    output logic             o_busy,
    output logic             o_dropped,
    input  logic [ROW_W-1:0] i_rd_row,
    input  logic [COL_W-1:0] i_rd_col,
    output logic [7:0]       o_rd_data,
    output logic [ROW_W-1:0] o_cur_row,
    output logic [COL_W-1:0] o_cur_col
);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW = $clog2(DEPTH);
    localparam logic [ROW_W:0] ROWS_X = (ROW_W+1)'(ROWS);
    localparam logic [COL_W:0] COLS_X = (COL_W+1)'(COLS);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {CLEAR, IDLE, CLRROW} state_t;

    state_t           state;
    logic [ROW_W-1:0] top_row;
    logic [AW-1:0]    clr_cnt;
    logic [ROW_W-1:0] clr_row;
    logic [COL_W-1:0] clr_col;
    logic [7:0]       mem [DEPTH];

    function automatic logic [ROW_W-1:0] wrap_row(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
        logic [ROW_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s >= ROWS_X ? ROW_W'(s - ROWS_X) : s[ROW_W-1:0];
    endfunction

    logic             accept, printable, last_col, last_row, do_nl;
    logic [ROW_W-1:0] cur_phys, rd_phys;
    logic [AW-1:0]    cur_addr, clr_addr, rd_addr;
    logic             rd_oob;

    assign accept    = i_wr && state == IDLE;
    assign printable = i_data >= 8'h20 && i_data <= 8'h7E;
    assign last_col  = o_cur_col == COL_W'(COLS - 1);
    assign last_row  = o_cur_row == ROW_W'(ROWS - 1);
    assign do_nl     = accept && ((printable && last_col) || i_data == 8'h0A);
    assign cur_phys  = wrap_row(o_cur_row, top_row);
    assign rd_phys   = wrap_row(i_rd_row, top_row);
    assign cur_addr  = AW'(cur_phys) * AW'(COLS) + AW'(o_cur_col);
    assign clr_addr  = AW'(clr_row) * AW'(COLS) + AW'(clr_col);
    assign rd_addr   = AW'(rd_phys) * AW'(COLS) + AW'(i_rd_col);
    assign rd_oob    = {1'b0, i_rd_row} >= ROWS_X || {1'b0, i_rd_col} >= COLS_X;
    assign o_busy    = state != IDLE;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    // Sweeps own the write port; cursor writes only happen in IDLE.
    always_comb begin
        we    = 1'b0;
        waddr = cur_addr;
        wdata = SPACE;
        if (state == CLEAR) begin
            we    = reset_n;
            waddr = clr_cnt;
        end else if (state == CLRROW) begin
            we    = reset_n;
            waddr = clr_addr;
        end else if (accept && printable) begin
            we    = 1'b1;
            wdata = i_data;
        end else if (accept && i_data == 8'h08 && o_cur_col != '0) begin
            we    = 1'b1;
            waddr = cur_addr - 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) o_rd_data <= SPACE;
        else o_rd_data <= rd_oob ? SPACE : mem[rd_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            top_row   <= '0;
            clr_cnt   <= '0;
            clr_row   <= '0;
            clr_col   <= '0;
            o_cur_row <= '0;
            o_cur_col <= '0;
            o_dropped <= 1'b0;
        end else begin
            o_dropped <= i_wr && state != IDLE;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1)) state <= IDLE;
                end
                CLRROW: begin
                    clr_col <= clr_col + 1'b1;
                    if (clr_col == COL_W'(COLS - 1)) state <= IDLE;
                end
                IDLE: if (i_wr) begin
                    if (printable) o_cur_col <= last_col ? '0 : o_cur_col + 1'b1;
                    else if (i_data == 8'h0D) o_cur_col <= '0;
                    else if (i_data == 8'h08 && o_cur_col != '0) o_cur_col <= o_cur_col - 1'b1;
                    else if (i_data == 8'h0C) begin
                        o_cur_row <= '0;
                        o_cur_col <= '0;
                        top_row   <= '0;
                        clr_cnt   <= '0;
                        state     <= CLEAR;
                    end
                    // At the bottom line, scroll by advancing the base and blanking the old top row.
                    if (do_nl) begin
                        if (!last_row) o_cur_row <= o_cur_row + 1'b1;
                        else begin
                            top_row <= top_row == ROW_W'(ROWS - 1) ? '0 : top_row + 1'b1;
                            clr_row <= top_row;
                            clr_col <= '0;
                            state   <= CLRROW;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: doc/text_console.md
TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 SHALL have parameter COLS, default 32: characters per row, range 2..128.
REQ-002 SHALL have parameter ROWS, default 16: rows on screen, range 2..64; powers of two are not required.
REQ-003 SHALL have parameter COL_W, default 5: column index width, with 2^COL_W >= COLS.
REQ-004 SHALL have parameter ROW_W, default 4: row index width, with 2^ROW_W >= ROWS.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_wr, input, 1 bit: one-cycle strobe marking i_data valid (UART RX o_wr style).
REQ-008 SHALL have port i_data, input, 8 bits: received byte.
REQ-009 SHALL have port o_busy, output, 1 bit: high while the block is clearing; a byte offered then is not accepted.
REQ-010 SHALL have port o_dropped, output, 1 bit: one-cycle pulse when i_wr arrives while o_busy=1.
REQ-011 SHALL have port i_rd_row, input, ROW_W bits: display read row, screen-relative (0 = top line).
REQ-012 SHALL have port i_rd_col, input, COL_W bits: display read column.
REQ-013 SHALL have port o_rd_data, output, 8 bits: character at the read position, registered.
REQ-014 SHALL have ports o_cur_row (ROW_W bits) and o_cur_col (COL_W bits), outputs: screen-relative cursor position.

Function
REQ-015 SHALL store COLS*ROWS bytes as a circular set of physical rows, with register top_row holding the physical row shown as screen row 0.
REQ-016 SHALL have state machine states CLEAR, IDLE and CLRROW; it SHALL accept bytes only in IDLE, and o_busy = (state != IDLE).
REQ-017 CLEAR SHALL write 0x20 to one cell per cycle across all COLS*ROWS cells, then enter IDLE.
REQ-018 CLRROW SHALL write 0x20 to one cell per cycle across COLS cells of the row to clear, then enter IDLE.
REQ-019 An accepted byte in 0x20..0x7E SHALL be written at the cursor on the accepting edge, and the cursor column SHALL increment.
REQ-020 When the column increment passes COLS-1, the cursor SHALL wrap to column 0 and perform a newline.
REQ-021 0x0D (CR) SHALL set the cursor column to 0.
REQ-022 0x0A (LF) SHALL perform a newline and leave the column unchanged.
REQ-023 0x08 (BS) with column > 0 SHALL decrement the column and write 0x20 at the new position; at column 0 it SHALL have no effect.
REQ-024 0x0C (FF) SHALL set the cursor to 0,0, set top_row to 0 and enter CLEAR.
REQ-025 Every other byte SHALL be ignored, and neither the cursor nor memory SHALL change.
REQ-026 Newline with cursor row < ROWS-1 SHALL increment the cursor row.
REQ-027 Newline with cursor row = ROWS-1 SHALL keep the cursor row, set top_row to (top_row+1) mod ROWS, and enter CLRROW on the physical row that was previously top_row.
REQ-028 The read path SHALL map physical row = (i_rd_row + top_row) mod ROWS, computed by add and conditional subtract (no divider).
REQ-029 o_rd_data SHALL appear exactly 1 clk after the address is presented.
REQ-030 A cell written on edge N SHALL be readable by an address presented in cycle N+1.
REQ-031 When i_rd_row >= ROWS or i_rd_col >= COLS, o_rd_data SHALL be 0x20.
REQ-032 The read port SHALL operate in every state; cells not yet cleared SHALL return the current memory contents.
REQ-033 When i_wr=1 and o_busy=1, o_dropped SHALL be 1 on the next cycle, and no state, cursor or memory change SHALL occur.
REQ-034 o_busy SHALL rise on the cycle after an accepted byte that triggers CLEAR or CLRROW; back-to-back bytes in IDLE SHALL all be accepted.

Reset
REQ-035 While reset_n=0: cursor 0,0; top_row 0; state CLEAR; o_busy 1; o_dropped 0; o_rd_data 0x20. Memory is not reset.
REQ-036 After reset_n rises, o_busy SHALL stay high for exactly COLS*ROWS cycles.
REQ-037 Assertion of reset_n during CLEAR or CLRROW SHALL abort the sweep; the full CLEAR SHALL restart on deassertion.

Verification
REQ-038 Reset release, COLS=32, ROWS=16 -> o_busy high for 512 cycles; every cell then reads 0x20.
REQ-039 Bytes "AB", CR, "C" -> row 0 col 0 = 'C', col 1 = 'B'; cursor 0,1.
REQ-040 33 printable bytes ('a'..) from home -> row 1 col 0 = 33rd byte; cursor 1,1.
REQ-041 16 LFs from home, then 'X' -> top_row=1, o_busy high 32 cycles, screen row 15 col 0 = 'X', former row 0 content gone.
REQ-042 i_wr strobed during CLRROW -> o_dropped pulses once, cursor unchanged; 'Z' after o_busy falls is written.
REQ-043 'Q', BS, BS, then FF mid-stream with reset_n pulsed during the CLEAR sweep -> cell 0,0 = 0x20, cursor 0,0, busy for 512 cycles after release.
